// File: rtl/ex_alu_pipe.sv
// Pipelined integer ALU: computes result and flags at dispatch, then carries them
// through DEPTH stages with stall backpressure, bubble collapse and flush.
module ex_alu_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DEPTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [2:0]        op,
  input  logic [TAG_W-1:0]  rd_in_rn,
  input  logic              ex_enable,
  output logic              ex_busy,
  input  logic              flush,
  input  logic              stall,
  output logic [DATA_W-1:0] out,
  output logic [TAG_W-1:0]  rd_out_rn,
  output logic [2:0]        flags,
  output logic              valid
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned MSB  = DATA_W - 1;
  localparam int unsigned LAST = DEPTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  logic [DATA_W:0]   add_ext_c;
  logic [DATA_W:0]   sub_ext_c;
  logic [SH_W-1:0]   shamt_c;
  logic [DATA_W-1:0] alu_res_c;
  logic              alu_cy_c;
  logic              alu_ov_c;
  logic              alu_zero_c;

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DEPTH-1:0]  adv_c;
  logic [DATA_W-1:0] res_q [DEPTH];
  logic [DATA_W-1:0] res_d [DEPTH];
  logic [2:0]        fl_q  [DEPTH];
  logic [2:0]        fl_d  [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];

  logic              ex_busy_c;
  logic              accept_c;

  // ALU datapath; SUB is in1 + ~in2 + 1 so the carry-out is the NOT-borrow
  always_comb begin
    add_ext_c  = {1'b0, in1} + {1'b0, in2};
    sub_ext_c  = {1'b0, in1} + {1'b0, ~in2} + (DATA_W + 1)'(1);
    shamt_c    = in2[SH_W-1:0];
    alu_res_c  = '0;
    alu_cy_c   = 1'b0;
    alu_ov_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_c = add_ext_c[DATA_W-1:0];
        alu_cy_c  = add_ext_c[DATA_W];
        alu_ov_c  = (in1[MSB] == in2[MSB]) && (alu_res_c[MSB] != in1[MSB]);
      end
      OP_SUB: begin
        alu_res_c = sub_ext_c[DATA_W-1:0];
        alu_cy_c  = sub_ext_c[DATA_W];
        alu_ov_c  = (in1[MSB] != in2[MSB]) && (alu_res_c[MSB] != in1[MSB]);
      end
      OP_AND: alu_res_c = in1 & in2;
      OP_OR:  alu_res_c = in1 | in2;
      OP_XOR: alu_res_c = in1 ^ in2;
      OP_SLL: alu_res_c = in1 << shamt_c;
      OP_SRL: alu_res_c = in1 >> shamt_c;
      OP_SRA: alu_res_c = DATA_W'($signed(in1) >>> shamt_c);
    endcase
    alu_zero_c = (alu_res_c == '0);
  end

  // Advance chain from the output back: a stage moves if empty or its successor moves
  always_comb begin
    logic a;
    adv_c       = '0;
    a           = !stall || !v_q[LAST];
    adv_c[LAST] = a;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      a        = !v_q[k] || a;
      adv_c[k] = a;
    end
  end

  assign ex_busy_c = v_q[0] && !adv_c[0];
  assign accept_c  = ex_enable && !ex_busy_c && !flush;

  // Data only loads with a valid op so outputs keep their last result when idle or flushed
  always_comb begin
    v_d   = v_q;
    res_d = res_q;
    fl_d  = fl_q;
    tag_d = tag_q;
    if (adv_c[0]) begin
      v_d[0] = accept_c;
      if (accept_c) begin
        res_d[0] = alu_res_c;
        fl_d[0]  = {alu_cy_c, alu_ov_c, alu_zero_c};
        tag_d[0] = rd_in_rn;
      end
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (adv_c[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          res_d[k] = res_q[k-1];
          fl_d[k]  = fl_q[k-1];
          tag_d[k] = tag_q[k-1];
        end
      end
    end
    if (flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        res_q[k] <= '0;
        fl_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      res_q <= res_d;
      fl_q  <= fl_d;
      tag_q <= tag_d;
    end
  end

  assign ex_busy   = ex_busy_c;
  assign valid     = v_q[LAST];
  assign out       = res_q[LAST];
  assign flags     = fl_q[LAST];
  assign rd_out_rn = tag_q[LAST];

endmodule

// File: doc/ex_alu_pipe.md
EX_ALU_PIPE -- requirements
Module: ex_alu_pipe

Interface
REQ-001 Parameter DATA_W, default 64, operand and result width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 6, destination register tag width.
REQ-003 Parameter DEPTH, default 3, pipeline stage count; legal values 1 to 8.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in1, in2  input  DATA_W  operands.
REQ-007 op  input  3  operation select.
REQ-008 rd_in_rn  input  TAG_W  destination tag.
REQ-009 ex_enable  input  1  dispatch request.
REQ-010 ex_busy  output  1  dispatch refused this cycle; combinational.
REQ-011 flush  input  1  synchronous squash of all in-flight ops.
REQ-012 stall  input  1  commit cannot take the output this cycle.
REQ-013 out  output  DATA_W  registered result.
REQ-014 rd_out_rn  output  TAG_W  registered tag.
REQ-015 flags  output  3  registered {carry, overflow, zero}.
REQ-016 valid  output  1  out, rd_out_rn and flags hold a result.

Function
REQ-017 op encoding: 0 ADD, 1 SUB (in1-in2), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
REQ-018 Shift amount SHALL be in2[log2(DATA_W)-1:0]; upper in2 bits ignored.
REQ-019 ADD/SUB result SHALL wrap modulo 2^DATA_W.
REQ-020 carry SHALL be the carry-out for ADD and the NOT-borrow for SUB; it SHALL be 0 for other ops.
REQ-021 overflow SHALL be signed overflow for ADD/SUB and 0 otherwise; zero SHALL be set when the result equals 0 for all ops.
REQ-022 Result and flags SHALL be computed from the inputs at accept and captured into stage 0.
REQ-023 Stages 1..DEPTH-1 SHALL carry valid, result, flags and tag unchanged; the last stage drives the outputs.
REQ-024 The last stage SHALL advance when stall=0 or its valid=0.
REQ-025 Stage k<DEPTH-1 SHALL advance when it is empty or stage k+1 advances, so bubbles collapse under stall.
REQ-026 ex_busy = valid[0] AND NOT advance[0].
REQ-027 An op SHALL be accepted when ex_enable=1, ex_busy=0 and flush=0.
REQ-028 An op presented while ex_busy=1 SHALL NOT be captured; the dispatcher holds it.
REQ-029 A stage that advances with no incoming op SHALL load valid=0; data in invalid stages is don't-care.
REQ-030 With no stall, latency from accept to valid=1 SHALL be exactly DEPTH cycles, at throughput 1 op/cycle.
REQ-031 Results SHALL leave in accept order with no drop or duplication.
REQ-032 With stall=1 and valid=1, out, rd_out_rn, flags and valid SHALL hold.
REQ-033 flush=1 SHALL clear every stage valid at the next edge, overriding stall and ex_enable.
REQ-034 After a flush, out, rd_out_rn and flags keep their last values while valid=0.
REQ-035 Simultaneous stall=0 and accept into a full pipe SHALL retire one op and accept one op in the same cycle.

Reset
REQ-036 While rst=1, all stage valids, valid, out, rd_out_rn and flags SHALL be 0, independent of clk.
REQ-037 ex_busy SHALL be 0 during and immediately after reset.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight ops; nothing emerges after release.

Verification
REQ-039 DEPTH=3, ADD 0xFFFF_FFFF_FFFF_FFFF + 1 accepted at cycle 0 -> cycle 3: valid=1, out=0, flags={1,0,1}.
REQ-040 SUB 0x8000_0000_0000_0000 - 1 -> out=0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry=1, zero=0.
REQ-041 SRA in1=0xF000_0000_0000_0000, in2=0x104 -> out=0xFF00_0000_0000_0000 (shift 4).
REQ-042 Stream tags 1..5, stall high for cycles 4-6 -> ex_busy=1 only once all 3 stages are full; tags emerge in order 1..5 with no loss.
REQ-043 Pipeline holds 3 valid ops, flush=1 for one cycle -> next cycle valid=0; a new op with tag 9 appears 3 cycles after its accept.
REQ-044 DEPTH=1, DATA_W=32, back-to-back XOR ops with stall=0 -> one result per cycle at latency 1.
